snake_move_controller: RTL

Sequences snake movement for the game core. It takes the decoded keypad direction stream, buffers up to two pending turns, and rejects duplicate and 180° turns against the most recent accepted direction. It generates the periodic move tick, applying one buffered turn per tick, and runs the IDLE/RUN/PAUSE/OVER game-flow state machine that gates all of this. It sits between the keypad direction decoder and the snake body/collision logic.

---
 rtl/snake_move_controller_if.sv | 23 ++
 rtl/snake_move_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/snake_move_controller_if.sv
// Bundle of the direction, game-flow and move-step signals between the
// keypad/collision logic and the snake move controller.
interface snake_move_controller_if;
    logic [1:0] dir_in;
    logic       dir_valid;
    logic       start;
    logic       pause;
    logic       game_over;
    logic       move_tick;
    logic [1:0] move_dir;
    logic [1:0] queue_count;
    logic [1:0] state;

    modport master (
        output dir_in, dir_valid, start, pause, game_over,
        input  move_tick, move_dir, queue_count, state
    );

    modport slave (
        input  dir_in, dir_valid, start, pause, game_over,
        output move_tick, move_dir, queue_count, state
    );
endinterface

// File: rtl/snake_move_controller.sv
// Snake movement sequencer: game-flow FSM, periodic move tick and a
// two-entry turn queue that filters duplicate and reversing turns.
module snake_move_controller #(
    parameter int TICK_DIV = 25_000_000
) (
    input logic                    clk,
    input logic                    rst,
    snake_move_controller_if.slave bus
);
    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [1:0]      DIR_RIGHT = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        OVER  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dir_q, dir_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             tick_q, tick_d;

    logic       active;
    logic       go_evt;
    logic       start_evt;
    logic       advance;
    logic       wrap;
    logic       pop;
    logic       push;
    logic [1:0] ref_dir;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        tick_d  = 1'b0;

        active    = (state_q == RUN) || (state_q == PAUSE);
        go_evt    = active && bus.game_over;
        start_evt = !active && bus.start;

        // Turns are judged against the newest accepted direction, which is
        // the queue tail when anything is pending.
        ref_dir = (count_q == 2'd2) ? tail_q :
                  (count_q == 2'd1) ? head_q : dir_q;
        push    = active && bus.dir_valid && (bus.dir_in != ref_dir) &&
                  ((bus.dir_in ^ ref_dir) != 2'b10) && (count_q != 2'd2);

        // The counter only moves on edges where the game stays in RUN.
        advance = (state_q == RUN) && !bus.game_over && !bus.pause;
        wrap    = advance && (cnt_q == CNT_MAX);
        pop     = wrap && (count_q != 2'd0);

        if (go_evt) begin
            state_d = OVER;
            count_d = 2'd0;
        end else if (start_evt) begin
            state_d = RUN;
            cnt_d   = '0;
            count_d = 2'd0;
            dir_d   = DIR_RIGHT;
        end else if (active) begin
            if (bus.pause) begin
                state_d = (state_q == RUN) ? PAUSE : RUN;
            end
            if (advance) begin
                cnt_d = wrap ? '0 : cnt_q + 1'b1;
            end
            tick_d = wrap;
            if (pop) begin
                dir_d = head_q;
            end
            // A simultaneous pop and push can only happen with one entry held.
            case ({pop, push})
                2'b10: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd0) begin
                        head_d = bus.dir_in;
                    end else begin
                        tail_d = bus.dir_in;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b11: begin
                    head_d = bus.dir_in;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= DIR_RIGHT;
            head_q  <= 2'b00;
            tail_q  <= 2'b00;
            count_q <= 2'd0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.move_tick   = tick_q;
    assign bus.move_dir    = dir_q;
    assign bus.queue_count = count_q;
    assign bus.state       = state_q;
endmodule
